// File: rtl/conway_frame_loader.sv
// Row-per-beat board loader for the 16x16 life stage. It commits a whole board with a
// one-cycle load pulse and drops malformed frames. Optional popcount output: CONWAY_LOADER_POPCOUNT_EN.
module conway_frame_loader #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [COLS-1:0]                in_row,
  input  logic                           in_last,
  output logic                           load,
  output logic [ROWS*COLS-1:0]           data,
  output logic                           frame_err,
  output logic                           busy,
  output logic [CNT_W-1:0]               frames_loaded,
`ifdef CONWAY_LOADER_POPCOUNT_EN
  output logic [$clog2(ROWS*COLS+1)-1:0] pop_count,
`endif
  output logic [1:0]                     state_dbg
);

  localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [RC_W-1:0]        row_cnt_q, row_cnt_d;
  logic [ROWS*COLS-1:0]   shadow_q, shadow_d, shadow_wr;
  logic [ROWS*COLS-1:0]   data_q, data_d;
  logic                   load_q, load_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       frames_q, frames_d;
  logic                   beat;

  // Handshake: a beat moves on a posedge where in_valid && in_ready; in_valid may drop
  // at any time without aborting a frame, and in_ready is low only in COMMIT and in reset.
  assign in_ready = !areset && (state_q != COMMIT);
  assign beat     = in_valid && in_ready;

`ifdef CONWAY_LOADER_POPCOUNT_EN
  localparam int PC_W = $clog2(ROWS*COLS+1);
  logic [PC_W-1:0] acc_q, acc_d, pop_q, pop_d;

  function automatic logic [PC_W-1:0] row_pop(input logic [COLS-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    shadow_d  = shadow_q;
    data_d    = data_q;
    load_d    = 1'b0;
    err_d     = 1'b0;
    frames_d  = frames_q;
    shadow_wr = shadow_q;
    shadow_wr[COLS*row_cnt_q +: COLS] = in_row;
`ifdef CONWAY_LOADER_POPCOUNT_EN
    acc_d = acc_q;
    pop_d = pop_q;
`endif

    unique case (state_q)
      // row_cnt is 0 in IDLE, so IDLE and FILL share the same beat handling.
      IDLE, FILL: begin
        if (beat) begin
          shadow_d = shadow_wr;
`ifdef CONWAY_LOADER_POPCOUNT_EN
          acc_d = ((state_q == IDLE) ? '0 : acc_q) + row_pop(in_row);
`endif
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            if (in_last) begin
              data_d   = shadow_wr;
              load_d   = 1'b1;
              frames_d = frames_q + CNT_W'(1);
`ifdef CONWAY_LOADER_POPCOUNT_EN
              pop_d = acc_d;
`endif
              state_d  = COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (in_last) begin
            err_d     = 1'b1;
            row_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            row_cnt_d = row_cnt_q + RC_W'(1);
            state_d   = FILL;
          end
        end
      end
      COMMIT: state_d = IDLE;
      DRAIN: begin
        if (beat && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      shadow_q  <= '0;
      data_q    <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      load_q    <= load_d;
      err_q     <= err_d;
      frames_q  <= frames_d;
    end
  end

`ifdef CONWAY_LOADER_POPCOUNT_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      acc_q <= '0;
      pop_q <= '0;
    end else begin
      acc_q <= acc_d;
      pop_q <= pop_d;
    end
  end
  assign pop_count = pop_q;
`endif

  assign load          = load_q;
  assign data          = data_q;
  assign frame_err     = err_q;
  assign frames_loaded = frames_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_conway_frame_loader.sv
// Scoreboard bench for conway_frame_loader: drivers push expected boards, a negedge
// monitor pops and compares on every load pulse.
module tb_conway_frame_loader;
  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int CNT_W = 8;
  localparam int W     = ROWS * COLS;
  localparam int PC_W  = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             areset;
  logic             in_valid;
  logic             in_ready;
  logic [COLS-1:0]  in_row;
  logic             in_last;
  logic             load;
  logic [W-1:0]     data;
  logic             frame_err;
  logic             busy;
  logic [CNT_W-1:0] frames_loaded;
  logic [1:0]       state_dbg;
`ifdef CONWAY_LOADER_POPCOUNT_EN
  logic [PC_W-1:0]  pop_count;
`endif

  conway_frame_loader #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .areset        (areset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_row        (in_row),
    .in_last       (in_last),
    .load          (load),
    .data          (data),
    .frame_err     (frame_err),
    .busy          (busy),
    .frames_loaded (frames_loaded),
`ifdef CONWAY_LOADER_POPCOUNT_EN
    .pop_count     (pop_count),
`endif
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard
  logic [W-1:0]     exp_q[$];
  logic [PC_W-1:0]  exp_pop_q[$];
  int               exp_cyc_q[$];
  logic [W-1:0]     mon_data   = '0;
  logic [CNT_W-1:0] mon_frames = '0;
  logic [PC_W-1:0]  mon_pop    = '0;
  int               err_seen   = 0;
  int               exp_err    = 0;

  always @(negedge clk) begin
    if (!areset) begin
      if (load) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got load=1 at cycle %0d expected no load", cyc);
        end else begin
          mon_data = exp_q.pop_front();
          mon_pop  = exp_pop_q.pop_front();
          chk("load_latency", W'(cyc), W'(exp_cyc_q.pop_front()));
          mon_frames = mon_frames + 1'b1;
        end
      end
      chk("data", data, mon_data);
      chk("frames_loaded", W'(frames_loaded), W'(mon_frames));
`ifdef CONWAY_LOADER_POPCOUNT_EN
      chk("pop_count", W'(pop_count), W'(mon_pop));
`endif
      if (frame_err) err_seen++;
    end
  end

  // drivers
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [COLS-1:0] row, input logic last, output int stalls);
    bit acc;
    acc    = 1'b0;
    stalls = 0;
    in_valid = 1'b1;
    in_row   = row;
    in_last  = last;
    for (int g = 0; g < 50 && !acc; g++) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) stalls++;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  logic [COLS-1:0] rows [ROWS];

  task automatic send_frame(input int nbeats, input bit bubble, output int stalls,
                            output int last_cyc);
    int s;
    logic [W-1:0]    board;
    logic [PC_W-1:0] pc;
    stalls = 0;
    last_cyc = 0;
    board = '0;
    pc = '0;
    for (int r = 0; r < ROWS; r++) begin
      board[COLS*r +: COLS] = rows[r];
      pc = pc + PC_W'($countones(rows[r]));
    end
    for (int i = 0; i < nbeats; i++) begin
      send_beat((i < ROWS) ? rows[i] : 16'hA5A5, (i == nbeats - 1), s);
      stalls += s;
      if (i == nbeats - 1) begin
        last_cyc = cyc;
        if (nbeats == ROWS) begin
          exp_q.push_back(board);
          exp_pop_q.push_back(pc);
          exp_cyc_q.push_back(cyc);
        end
      end else if (bubble) begin
        idle(1);
      end
    end
  endtask

  // stimulus
  int st, lc, prev_lc, s;
  logic [W-1:0]     diag, glider;
  logic [CNT_W-1:0] model_frames;

  initial begin
    areset = 1'b0; in_valid = 1'b0; in_row = '0; in_last = 1'b0;
    model_frames = '0;
    #1 areset = 1'b1;
    #1;
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_load", W'(load), W'(0));
    chk("rst_data", data, W'(0));
    chk("rst_frame_err", W'(frame_err), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_frames", W'(frames_loaded), W'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) areset = 1'b0;
    #1 chk("ready_after_release", W'(in_ready), W'(1));
    @(posedge clk); #1;

    // 1: diagonal frame
    for (int r = 0; r < ROWS; r++) rows[r] = 16'h0001 << r;
    diag = '0;
    for (int r = 0; r < ROWS; r++) diag[COLS*r + r] = 1'b1;
    send_frame(ROWS, 1'b0, st, lc);
    model_frames++;
    chk("t1_load_now", W'(load), W'(1));
    idle(2);
    chk("t1_diag", data, diag);
    chk("t1_frames", W'(frames_loaded), W'(model_frames));
`ifdef CONWAY_LOADER_POPCOUNT_EN
    chk("t1_pop", W'(pop_count), W'(16));
`endif

    // 2: glider with bubbles
    for (int r = 0; r < ROWS; r++) rows[r] = '0;
    rows[0] = 16'h0002; rows[1] = 16'h0004; rows[2] = 16'h0007;
    glider = '0;
    glider[1] = 1'b1; glider[COLS+2] = 1'b1;
    glider[2*COLS +: 3] = 3'b111;
    send_frame(ROWS, 1'b1, st, lc);
    model_frames++;
    idle(2);
    chk("t2_glider", data, glider);
    chk("t2_no_err", W'(err_seen), W'(exp_err));

    // 3: short frame then a good one
    for (int r = 0; r < ROWS; r++) rows[r] = 16'hFFFF >> r;
    send_frame(5, 1'b0, st, lc);
    chk("t3_err_pulse", W'(frame_err), W'(1));
    exp_err++;
    idle(2);
    chk("t3_err_count", W'(err_seen), W'(exp_err));
    chk("t3_data_kept", data, glider);
    chk("t3_idle", W'(busy), W'(0));
    send_frame(ROWS, 1'b0, st, lc);
    model_frames++;
    idle(2);

    // 4: long frame, beat 17 drained
    for (int i = 0; i < ROWS; i++) begin
      send_beat(16'h1234 ^ COLS'(i), 1'b0, s);
      chk("t4_no_stall", W'(s), W'(0));
    end
    chk("t4_err_after_16", W'(frame_err), W'(1));
    chk("t4_busy_drain", W'(busy), W'(1));
    exp_err++;
    send_beat(16'hBEEF, 1'b1, s);
    chk("t4_drain_ready", W'(s), W'(0));
    chk("t4_err_single", W'(frame_err), W'(0));
    idle(2);
    chk("t4_err_count", W'(err_seen), W'(exp_err));
    chk("t4_idle", W'(busy), W'(0));

    // 5: back-to-back frames through the counter wrap
    prev_lc = 0;
    for (int k = 0; k < 253; k++) begin
      for (int r = 0; r < ROWS; r++) rows[r] = COLS'(k * 37 + r * 4099);
      send_frame(ROWS, 1'b0, st, lc);
      model_frames++;
      chk("t5_stalls", W'(st), W'((k == 0) ? 0 : 1));
      if (k > 0) chk("t5_spacing", W'(lc - prev_lc), W'(17));
      prev_lc = lc;
    end
    idle(2);
    chk("t5_wrap", W'(frames_loaded), W'(model_frames));
    chk("t5_wrap_zero", W'(model_frames), W'(0));

    // 6: reset mid-frame
    for (int i = 0; i < 9; i++) send_beat(16'h00F0 | COLS'(i), 1'b0, s);
    chk("t6_busy", W'(busy), W'(1));
    #2 areset = 1'b1;
    mon_data = '0; mon_frames = '0; mon_pop = '0;
    model_frames = '0;
    #1;
    chk("t6_data0", data, W'(0));
    chk("t6_frames0", W'(frames_loaded), W'(0));
    chk("t6_load0", W'(load), W'(0));
    chk("t6_ready0", W'(in_ready), W'(0));
    chk("t6_busy0", W'(busy), W'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) areset = 1'b0;
    @(posedge clk); #1;
    idle(3);
    chk("t6_no_load", W'(exp_q.size()), W'(0));
    for (int r = 0; r < ROWS; r++) rows[r] = 16'h8001 | (16'h0100 >> r);
    send_frame(ROWS, 1'b0, st, lc);
    model_frames++;
    idle(3);
    chk("t6_frames1", W'(frames_loaded), W'(model_frames));

    idle(3);
    chk("queue_drained", W'(exp_q.size()), W'(0));
    chk("err_total", W'(err_seen), W'(exp_err));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
